rgb_hue_pwm: RTL and testbench
==============================

Name: rgb_hue_pwm

Overview:
Generates a continuously cycling colour-wheel pattern for the board's RGB LED. A prescaled hue state machine sweeps six colour-wheel segments. Three PWM channels convert the per-colour duty values into active-low LED drive bits. Outputs feed the downstream gating logic, which ANDs each channel with a user enable before the LED pads.

Parameters:
PWM_BITS, 8, width of duty values and of the PWM counter (period = 2^PWM_BITS clocks)
STEP_DIV, 46875, clocks per hue step (12 MHz / 46875 = 256 steps/s, ~6 s per revolution at defaults); legal range >= 2

Ports:
clk  input  1  system clock (12 MHz on board)
rst  input  1  synchronous active-high reset
en  input  1  run enable; low = LEDs off, counters held
pause  input  1  freeze hue progression; PWM keeps running
r_n  output  1  red drive, active-low, registered
g_n  output  1  green drive, active-low, registered
b_n  output  1  blue drive, active-low, registered
hue_seg  output  3  current segment 0..5
level  output  PWM_BITS  ramp position within segment
wrap  output  1  one-cycle pulse on SEG5->SEG0 transition

Behaviour:
- Reset (rst=1 at a clk edge, dominates all inputs):
  - seg=SEG0, level=0, prescaler=0, pwm_cnt=0, latched duties=0.
  - r_n=g_n=b_n=1, wrap=0.
- Prescaler: counts 0..STEP_DIV-1 while en=1 and pause=0.
  - tick=1 in the cycle it equals STEP_DIV-1; it then returns to 0.
  - en=0 clears it to 0. pause=1 holds its value.
- Hue FSM advances only on tick:
  - If level < MAX (2^PWM_BITS-1), level increments.
  - Else level<=0 and seg advances; SEG5->SEG0 also asserts wrap for exactly one cycle.
- Segment duties (MAX=all ones, L=level):
  - SEG0 R=MAX G=L B=0
  - SEG1 R=MAX-L G=MAX B=0
  - SEG2 R=0 G=MAX B=L
  - SEG3 R=0 G=MAX-L B=MAX
  - SEG4 R=L G=0 B=MAX
  - SEG5 R=MAX B=MAX-L G=0
  - Illegal seg encodings (6,7) return to SEG0 with level=0 on the next clk.
- PWM counter: PWM_BITS-wide, free-running +1 per clk while en=1, wraps MAX->0. en=0 holds it at 0.
- Duty latch: the per-channel duty registers load the segment duties when pwm_cnt==MAX, so duty changes never occur mid-period.
- Channel on = (pwm_cnt < duty_q). Duty 0 is never on; duty MAX is on for MAX of 2^PWM_BITS clocks.
- Outputs: X_n <= ~(en & on_X), registered, 1-cycle latency from pwm_cnt.
- en falling: all outputs are 1 on the next edge. seg and level are retained, and resume when en rises.
- pause and tick never coincide, because pause blocks the prescaler.
- hue_seg and level reflect the FSM registers directly.

Decomposition:
- Shared package rgb_pkg:
  - seg_t enum: SEG0..SEG5, 3 bits.
  - SEG_COUNT=6.
  - Helper function returning the {r,g,b} duty triple from (seg, level).
- Sub-module pwm_channel, instantiated 3x:
  - Inputs: clk, rst, en, load, duty_in, pwm_cnt.
  - Holds duty_q and the registered active-low output.
- Prescaler, hue FSM and the shared pwm_cnt stay in the top module.

Test Plan:
All scenarios use PWM_BITS=4, STEP_DIV=4.
- Reset: hold rst 3 cycles with en=1 -> r_n=g_n=b_n=1, hue_seg=0, level=0, wrap=0. Release -> level=1 exactly 4 clocks later.
- Hue stepping: run en=1 for 16*4 clocks -> level walks 0..15, then hue_seg=1 and level=0. After 6*16*4 clocks, wrap pulses high for 1 cycle and hue_seg=0.
- PWM duty: force seg0 with level=5 (after latch) -> g_n low for exactly 5 of 16 clocks per period, r_n low for 15 of 16, b_n constantly 1.
- Glitch-free latch: a level change mid-period -> g_n low-count in the current period is unchanged; the new count applies from the period after pwm_cnt==15.
- pause/en:
  - pause=1 for 100 clocks -> level and hue_seg frozen while PWM keeps toggling.
  - en=0 -> all outputs are 1 next cycle and pwm_cnt=0; re-enable resumes from the held seg/level.
- Mid-operation reset: assert rst in SEG3 with level=9 -> next edge gives hue_seg=0, level=0, outputs all 1.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB colour-wheel generator.
package rgb_pkg;

  // Colour-wheel segments; encodings 6 and 7 are unused.
  typedef enum logic [2:0] {
    SEG0 = 3'd0,
    SEG1 = 3'd1,
    SEG2 = 3'd2,
    SEG3 = 3'd3,
    SEG4 = 3'd4,
    SEG5 = 3'd5
  } seg_t;

  localparam int SEG_COUNT = 6;

  // How one channel's duty is derived from the ramp level inside a segment.
  // Kept width-independent so the package serves any PWM resolution.
  typedef enum logic [1:0] {
    DUTY_ZERO = 2'd0,
    DUTY_FULL = 2'd1,
    DUTY_UP   = 2'd2,
    DUTY_DOWN = 2'd3
  } duty_sel_t;

  typedef struct packed {
    duty_sel_t r;
    duty_sel_t g;
    duty_sel_t b;
  } rgb_sel_t;

  // The colour wheel: each segment holds one channel full, one off, and ramps the third.
  function automatic rgb_sel_t segDutySel(seg_t seg);
    rgb_sel_t sel;
    sel = '{r: DUTY_ZERO, g: DUTY_ZERO, b: DUTY_ZERO};
    case (seg)
      SEG0:    sel = '{r: DUTY_FULL, g: DUTY_UP,   b: DUTY_ZERO};
      SEG1:    sel = '{r: DUTY_DOWN, g: DUTY_FULL, b: DUTY_ZERO};
      SEG2:    sel = '{r: DUTY_ZERO, g: DUTY_FULL, b: DUTY_UP};
      SEG3:    sel = '{r: DUTY_ZERO, g: DUTY_DOWN, b: DUTY_FULL};
      SEG4:    sel = '{r: DUTY_UP,   g: DUTY_ZERO, b: DUTY_FULL};
      SEG5:    sel = '{r: DUTY_FULL, g: DUTY_ZERO, b: DUTY_DOWN};
      default: sel = '{r: DUTY_ZERO, g: DUTY_ZERO, b: DUTY_ZERO};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rgb_hue_pwm_channel.sv
// One PWM channel: a period-aligned duty register and a registered active-low drive.
module pwm_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                out_n
);

  logic [PWM_BITS-1:0] duty_q;
  logic                outN_q;

  // Take the new duty only at the end of a period and drive the LED low while the counter is below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      outN_q <= 1'b1;
    end else begin
      if (load) begin
        duty_q <= duty_in;
      end
      outN_q <= ~(en & (pwm_cnt < duty_q));
    end
  end

  assign out_n = outN_q;

endmodule

// File: rtl/rgb_hue_pwm.sv
// Colour-wheel RGB LED driver: prescaled hue sweep feeding three PWM channels.
module rgb_hue_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 46875
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                pause,
  output logic                r_n,
  output logic                g_n,
  output logic                b_n,
  output logic [2:0]          hue_seg,
  output logic [PWM_BITS-1:0] level,
  output logic                wrap
);

  localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  logic [PRE_W-1:0]    prescale_q, prescale_d;
  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic                tick;
  seg_t                seg_q;
  logic [PWM_BITS-1:0] level_q;
  logic                wrap_q;
  logic                loadDuty;
  rgb_sel_t            rgbSel;
  logic [PWM_BITS-1:0] dutyR, dutyG, dutyB;

  function automatic logic [PWM_BITS-1:0] resolveDuty(duty_sel_t sel, logic [PWM_BITS-1:0] lvl);
    logic [PWM_BITS-1:0] d;
    case (sel)
      DUTY_ZERO: d = '0;
      DUTY_FULL: d = PWM_MAX;
      DUTY_UP:   d = lvl;
      DUTY_DOWN: d = PWM_MAX - lvl;
      default:   d = '0;
    endcase
    return d;
  endfunction

  // Prescaler next state: cleared while disabled, frozen while paused, otherwise counts modulo STEP_DIV.
  always_comb begin
    prescale_d = prescale_q;
    if (!en) begin
      prescale_d = '0;
    end else if (!pause) begin
      prescale_d = (prescale_q == PRE_LAST) ? '0 : prescale_q + PRE_W'(1);
    end
  end

  assign tick = en & ~pause & (prescale_q == PRE_LAST);

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  // Shared PWM counter next state: free-running while enabled, parked at zero otherwise.
  always_comb begin
    pwmCnt_d = en ? pwmCnt_q + PWM_BITS'(1) : '0;
  end

  // Shared PWM counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt_q <= '0;
    end else begin
      pwmCnt_q <= pwmCnt_d;
    end
  end

  // Hue FSM: ramp the level on each tick, step to the next segment when the ramp tops out.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= SEG0;
      level_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (seg_q)
        SEG0, SEG1, SEG2, SEG3, SEG4, SEG5: begin
          if (tick) begin
            if (level_q != PWM_MAX) begin
              level_q <= level_q + PWM_BITS'(1);
            end else begin
              level_q <= '0;
              case (seg_q)
                SEG0:    seg_q <= SEG1;
                SEG1:    seg_q <= SEG2;
                SEG2:    seg_q <= SEG3;
                SEG3:    seg_q <= SEG4;
                SEG4:    seg_q <= SEG5;
                default: begin
                  seg_q  <= SEG0;
                  wrap_q <= 1'b1;
                end
              endcase
            end
          end
        end
        default: begin
          seg_q   <= SEG0;
          level_q <= '0;
        end
      endcase
    end
  end

  // Map the current segment and level onto the three channel duties.
  always_comb begin
    rgbSel = segDutySel(seg_q);
    dutyR  = resolveDuty(rgbSel.r, level_q);
    dutyG  = resolveDuty(rgbSel.g, level_q);
    dutyB  = resolveDuty(rgbSel.b, level_q);
  end

  assign loadDuty = (pwmCnt_q == PWM_MAX);

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (loadDuty),
    .duty_in(dutyR),
    .pwm_cnt(pwmCnt_q),
    .out_n  (r_n)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (loadDuty),
    .duty_in(dutyG),
    .pwm_cnt(pwmCnt_q),
    .out_n  (g_n)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (loadDuty),
    .duty_in(dutyB),
    .pwm_cnt(pwmCnt_q),
    .out_n  (b_n)
  );

  assign hue_seg = seg_q;
  assign level   = level_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_rgb_hue_pwm.sv
// Self-checking bench for rgb_hue_pwm with a small PWM and fast hue steps.
module tb_rgb_hue_pwm;

  localparam int PB   = 4;
  localparam int SD   = 4;
  localparam int MAXV = (1 << PB) - 1;
  localparam int PER  = 1 << PB;
  localparam int HUES = 6 * PER;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pause;
  logic          r_n, g_n, b_n;
  logic [2:0]    hue_seg;
  logic [PB-1:0] level;
  logic          wrap;

  int vectors     = 0;
  int miscompares = 0;

  int mPre, mPwm, mHue, mWrap;
  int mDuty [3];
  int mOut  [3];

  rgb_hue_pwm #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .pause  (pause),
    .r_n    (r_n),
    .g_n    (g_n),
    .b_n    (b_n),
    .hue_seg(hue_seg),
    .level  (level),
    .wrap   (wrap)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Duty of channel ch (0=R,1=G,2=B) at overall wheel position hue = seg*PER + level.
  function automatic int channelDuty(int hue, int ch);
    int seg, l;
    int tr [3];
    seg = hue / PER;
    l   = hue % PER;
    case (seg)
      0:       tr = '{MAXV,     l,        0};
      1:       tr = '{MAXV - l, MAXV,     0};
      2:       tr = '{0,        MAXV,     l};
      3:       tr = '{0,        MAXV - l, MAXV};
      4:       tr = '{l,        0,        MAXV};
      default: tr = '{MAXV,     0,        MAXV - l};
    endcase
    return tr[ch];
  endfunction

  // Reference model: one clock edge of the colour wheel, all state taken from pre-edge values.
  task automatic modelStep(input logic r, input logic e, input logic p);
    int oldPwm;
    bit tk;
    if (r) begin
      mPre = 0; mPwm = 0; mHue = 0; mWrap = 0;
      for (int c = 0; c < 3; c++) begin
        mDuty[c] = 0;
        mOut[c]  = 1;
      end
    end else begin
      oldPwm = mPwm;
      tk     = e && !p && (mPre == SD - 1);
      for (int c = 0; c < 3; c++) mOut[c] = (e && oldPwm < mDuty[c]) ? 0 : 1;
      if (oldPwm == MAXV)
        for (int c = 0; c < 3; c++) mDuty[c] = channelDuty(mHue, c);
      mWrap = 0;
      if (tk) begin
        if (mHue == HUES - 1) begin
          mHue  = 0;
          mWrap = 1;
        end else begin
          mHue = mHue + 1;
        end
      end
      if (!e)      mPre = 0;
      else if (!p) mPre = (mPre + 1) % SD;
      mPwm = e ? (oldPwm + 1) % PER : 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("r_n",     32'(r_n),     32'(mOut[0]));
    check("g_n",     32'(g_n),     32'(mOut[1]));
    check("b_n",     32'(b_n),     32'(mOut[2]));
    check("hue_seg", 32'(hue_seg), 32'(mHue / PER));
    check("level",   32'(level),   32'(mHue % PER));
    check("wrap",    32'(wrap),    32'(mWrap));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic p);
    rst   = r;
    en    = e;
    pause = p;
    @(posedge clk);
    modelStep(r, e, p);
    #1;
    checkOutput();
  endtask

  initial begin
    int lowR, lowG, lowB, wraps, expG, lvlStart, savedSeg, savedLvl, steps;
    logic [2:0] segAtWrap;
    rst = 1'b1; en = 1'b1; pause = 1'b0;

    // Reset held three cycles with en high.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0);
    check("rst_r_n", 32'(r_n), 1);
    check("rst_g_n", 32'(g_n), 1);
    check("rst_b_n", 32'(b_n), 1);
    check("rst_seg", 32'(hue_seg), 0);
    check("rst_level", 32'(level), 0);
    check("rst_wrap", 32'(wrap), 0);

    // First hue step lands exactly four clocks after release.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 0);
      if (i == 3) check("first_step_early", 32'(level), 0);
      if (i == 4) check("first_step", 32'(level), 1);
    end

    // Walk a whole revolution; segment 1 begins at clock 64, wrap arrives at clock 384.
    wraps = 0;
    segAtWrap = 3'd7;
    for (int i = 5; i <= HUES * SD; i++) begin
      applyStimulus(0, 1, 0);
      if (i == PER * SD) begin
        check("seg1_entry_seg", 32'(hue_seg), 1);
        check("seg1_entry_level", 32'(level), 0);
      end
      if (wrap === 1'b1) begin
        wraps++;
        segAtWrap = hue_seg;
      end
    end
    check("wrap_at_rev", 32'(wrap), 1);
    check("wrap_count", 32'(wraps), 1);
    check("wrap_seg", 32'(segAtWrap), 0);
    applyStimulus(0, 1, 0);
    check("wrap_one_cycle", 32'(wrap), 0);

    // Reach seg0 level 5 and freeze the hue for 100 clocks.
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 5 * SD; i++) applyStimulus(0, 1, 0);
    check("pre_pause_level", 32'(level), 5);
    for (int i = 0; i < 100 - PER; i++) applyStimulus(0, 1, 1);
    lowR = 0; lowG = 0; lowB = 0;
    for (int i = 0; i < PER; i++) begin
      applyStimulus(0, 1, 1);
      lowR += (r_n === 1'b0) ? 1 : 0;
      lowG += (g_n === 1'b0) ? 1 : 0;
      lowB += (b_n === 1'b0) ? 1 : 0;
    end
    check("duty_r_lows", 32'(lowR), 15);
    check("duty_g_lows", 32'(lowG), 5);
    check("duty_b_lows", 32'(lowB), 0);
    check("pause_level", 32'(level), 5);
    check("pause_seg", 32'(hue_seg), 0);

    // Unpause and line up with a period start; the level moves mid-period but the duty must not.
    steps = 0;
    do begin
      applyStimulus(0, 1, 0);
      steps++;
    end while (mPwm != 0 && steps < 2 * PER);
    check("align_budget", 32'(mPwm), 0);
    for (int k = 0; k < 2; k++) begin
      expG     = mDuty[1];
      lvlStart = int'(level);
      lowG     = 0;
      for (int i = 0; i < PER; i++) begin
        applyStimulus(0, 1, 0);
        lowG += (g_n === 1'b0) ? 1 : 0;
      end
      check("glitchfree_g_lows", 32'(lowG), 32'(expG));
      check("level_moved", 32'(int'(level) != lvlStart), 1);
    end

    // Drop en: outputs off next edge, hue held, then resume from where it was.
    savedSeg = int'(hue_seg);
    savedLvl = int'(level);
    applyStimulus(0, 0, 0);
    check("en_off_r_n", 32'(r_n), 1);
    check("en_off_g_n", 32'(g_n), 1);
    check("en_off_b_n", 32'(b_n), 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, $urandom_range(0, 1));
    check("en_off_seg_held", 32'(hue_seg), 32'(savedSeg));
    check("en_off_level_held", 32'(level), 32'(savedLvl));
    for (int i = 0; i < 3 * PER; i++) applyStimulus(0, 1, 0);

    // Randomised run against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0));
    end

    // Mid-operation reset from seg3 level 9.
    applyStimulus(1, 1, 0);
    steps = 0;
    while (mHue != 3 * PER + 9 && steps < 2 * HUES * SD) begin
      applyStimulus(0, 1, 0);
      steps++;
    end
    check("reach_seg3", 32'(hue_seg), 3);
    check("reach_level9", 32'(level), 9);
    applyStimulus(1, 1, 0);
    check("midrst_seg", 32'(hue_seg), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_r_n", 32'(r_n), 1);
    check("midrst_g_n", 32'(g_n), 1);
    check("midrst_b_n", 32'(b_n), 1);
    check("midrst_wrap", 32'(wrap), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
